// File: rtl/mem_responder.sv
// mem_responder: target end of the single-master mem_req/mem_write/mem_addr/mem_wdata
// protocol. Holds a 2**DEPTH_AW-word array, commits writes immediately, returns read
// data in request order READ_LAT cycles after the request, flags out-of-range
// accesses and keeps saturating read/write counters for debug.
//
// Ports:
//   clk            clock, all state on posedge
//   rst_n          async active-low reset (array contents are retained)
//   mem_req        request valid, one access per cycle high
//   mem_write      1=write, 0=read
//   mem_addr       word address
//   mem_wdata      write data
//   mem_rdata_vld  one-cycle pulse per read response
//   mem_rdata      read data, 0 whenever mem_rdata_vld=0
//   mem_err        pulse on out-of-range write (cycle after) or read (with response)
//   rd_cnt/wr_cnt  saturating accepted-access counters
module mem_responder #(
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int DEPTH_AW = 8,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  output logic              mem_err,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
);

  localparam int DEPTH = 2 ** DEPTH_AW;

  logic [MEM_DW-1:0]   mem [DEPTH];
  logic                in_range;
  logic [DEPTH_AW-1:0] idx;
  logic                wr_fire;
  logic                rd_fire;
  logic [MEM_DW-1:0]   rd_word;

  logic [READ_LAT-1:0] pipe_vld;
  logic [READ_LAT-1:0] pipe_err;
  logic [MEM_DW-1:0]   pipe_data [READ_LAT];
  logic                wr_err_q;
  logic [15:0]         rd_cnt_q;
  logic [15:0]         wr_cnt_q;

  // Upper address bits only exist when the array is smaller than the address space.
  generate
    if (DEPTH_AW == MEM_AW) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range = (mem_addr[MEM_AW-1:DEPTH_AW] == '0);
    end
  endgenerate

  assign idx     = mem_addr[DEPTH_AW-1:0];
  assign wr_fire = mem_req & mem_write;
  assign rd_fire = mem_req & ~mem_write;
  assign rd_word = in_range ? mem[idx] : '0;

  // Array is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_fire && in_range) begin
      mem[idx] <= mem_wdata;
    end
  end

  // Stage 0 captures the array at the request edge; data is zeroed in empty slots so
  // mem_rdata reads 0 whenever vld is low without an output mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int k = 0; k < READ_LAT; k++) begin
        pipe_data[k] <= '0;
      end
    end else begin
      pipe_vld[0]  <= rd_fire;
      pipe_err[0]  <= rd_fire & ~in_range;
      pipe_data[0] <= rd_fire ? rd_word : '0;
      for (int k = 1; k < READ_LAT; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_err[k]  <= pipe_err[k-1];
        pipe_data[k] <= pipe_data[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      wr_err_q <= wr_fire & ~in_range;
      if (rd_fire && rd_cnt_q != 16'hFFFF) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (wr_fire && wr_cnt_q != 16'hFFFF) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign mem_rdata_vld = pipe_vld[READ_LAT-1];
  assign mem_rdata     = pipe_data[READ_LAT-1];
  assign mem_err       = pipe_err[READ_LAT-1] | wr_err_q;
  assign rd_cnt        = rd_cnt_q;
  assign wr_cnt        = wr_cnt_q;

endmodule
